// File: rtl/imm_ctrl_pkg.sv
// Shared constants for the immediate-operand controller: data widths,
// decoded opcodes and the out_kind encoding seen by execute.
package imm_ctrl_pkg;

  localparam int DATASIZE    = 16;
  localparam int EXTEND9SIZE = 9;
  localparam int EXTEND6SIZE = 6;

  localparam logic [3:0] OP_I6  = 4'h1;
  localparam logic [3:0] OP_I9  = 4'h8;
  localparam logic [3:0] OP_LHI = 4'h3;
  localparam logic [3:0] OP_LIW = 4'hF;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_LHI  = 2'd2,
    IMM_WIDE = 2'd3
  } imm_kind_e;

endpackage

// File: rtl/signex6.sv
// 6-bit to datapath-width sign extender.
module signex6
  import imm_ctrl_pkg::*;
(
  input  logic [EXTEND6SIZE-1:0] in_val,
  output logic [DATASIZE-1:0]    out_val
);

  assign out_val = {{(DATASIZE-EXTEND6SIZE){in_val[EXTEND6SIZE-1]}}, in_val};

endmodule

// File: rtl/signex9.sv
// 9-bit to datapath-width sign extender.
module signex9
  import imm_ctrl_pkg::*;
(
  input  logic [EXTEND9SIZE-1:0] in_val,
  output logic [DATASIZE-1:0]    out_val
);

  assign out_val = {{(DATASIZE-EXTEND9SIZE){in_val[EXTEND9SIZE-1]}}, in_val};

endmodule

// File: rtl/imm_ctrl.sv
// Immediate-operand controller: decodes each fetched word into one registered
// immediate for execute, sequencing the two-word load-immediate-wide form.
module imm_ctrl
  import imm_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATASIZE-1:0] in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATASIZE-1:0] out_imm,
  output logic [1:0]          out_kind,
  output logic                busy
);

  typedef enum logic {
    IDLE     = 1'b0,
    LIW_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATASIZE-1:0] out_imm_q, out_imm_d;
  imm_kind_e           out_kind_q, out_kind_d;

  logic [DATASIZE-1:0] sext9, sext6, lhi_imm;
  logic                xfer_in, xfer_out;

  signex9 u_signex9 (
    .in_val  (in_instr[EXTEND9SIZE-1:0]),
    .out_val (sext9)
  );

  signex6 u_signex6 (
    .in_val  (in_instr[EXTEND6SIZE-1:0]),
    .out_val (sext6)
  );

  assign lhi_imm  = {in_instr[EXTEND9SIZE-1:0], {(DATASIZE-EXTEND9SIZE){1'b0}}};
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_kind_d  = out_kind_q;

    if (flush) begin
      // Stale immediate/kind are deliberately left in place; only valid drops.
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      if (xfer_out) out_valid_d = 1'b0;
      if (xfer_in) begin
        unique case (state_q)
          IDLE: begin
            out_valid_d = 1'b1;
            case (in_instr[15:12])
              OP_I6: begin
                out_imm_d  = sext6;
                out_kind_d = IMM_SEXT;
              end
              OP_I9: begin
                out_imm_d  = sext9;
                out_kind_d = IMM_SEXT;
              end
              OP_LHI: begin
                out_imm_d  = lhi_imm;
                out_kind_d = IMM_LHI;
              end
              OP_LIW: begin
                // Opcode word yields nothing; the literal follows.
                out_valid_d = 1'b0;
                state_d     = LIW_WAIT;
              end
              default: begin
                out_imm_d  = '0;
                out_kind_d = IMM_NONE;
              end
            endcase
          end
          LIW_WAIT: begin
            out_imm_d   = in_instr;
            out_kind_d  = IMM_WIDE;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_kind_q  <= IMM_NONE;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_kind_q  <= out_kind_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_kind  = out_kind_q;
  assign busy      = (state_q == LIW_WAIT);

endmodule

// File: tb/tb_imm_ctrl.sv
// Self-checking bench for imm_ctrl: table of single-word decodes plus
// directed LIW, backpressure, flush and async-reset sequences.
module tb_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_kind;
  logic        busy;

  int checks = 0;
  int errors = 0;

  imm_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_kind  (out_kind),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] exp_imm;
    logic [1:0]  exp_kind;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [15:0] imm,
                         input logic [1:0] kind);
    chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, ".imm"}, {16'd0, out_imm}, {16'd0, imm});
    chk({name, ".kind"}, {30'd0, out_kind}, {30'd0, kind});
    $display("txn %s: valid=%0b imm=%h kind=%0d busy=%0b", name, out_valid, out_imm, out_kind, busy);
  endtask

  initial begin
    vecs[0] = '{16'h81FF, 16'hFFFF, 2'd1};
    vecs[1] = '{16'h80FF, 16'h00FF, 2'd1};
    vecs[2] = '{16'h1020, 16'hFFE0, 2'd1};
    vecs[3] = '{16'h101F, 16'h001F, 2'd1};
    vecs[4] = '{16'h3155, 16'hAA80, 2'd2};
    vecs[5] = '{16'h31FF, 16'hFF80, 2'd2};
    vecs[6] = '{16'h0ABC, 16'h0000, 2'd0};
    vecs[7] = '{16'h7FFF, 16'h0000, 2'd0};
    vecs[8] = '{16'h8100, 16'hFF00, 2'd1};
    vecs[9] = '{16'h1FFF, 16'hFFFF, 2'd1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_out("reset", 1'b0, 16'h0000, 2'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);

    // Back-to-back single-word decodes with execute always ready.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr;
      step();
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_imm, vecs[i].exp_kind);
    end

    // LIW with an idle cycle between opcode and literal; literal not decoded.
    in_instr = 16'hF000;
    step();
    chk("liw1.valid", {31'd0, out_valid}, 32'd0);
    chk("liw1.busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("liw_gap.busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b1; in_instr = 16'h8123;
    step();
    chk_out("liw2", 1'b1, 16'h8123, 2'd3);
    chk("liw2.busy", {31'd0, busy}, 32'd0);

    // Backpressure: hold 81FF result for 3 cycles, then no-bubble handoff.
    in_instr = 16'h81FF;
    step();
    chk_out("bp_load", 1'b1, 16'hFFFF, 2'd1);
    out_ready = 1'b0; in_instr = 16'h1020;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 16'hFFFF, 2'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk_out("bp_rel", 1'b1, 16'hFFE0, 2'd1);
    in_valid = 1'b0;
    step();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // Flush while waiting for an LIW literal.
    in_valid = 1'b1; in_instr = 16'hF000;
    step();
    chk("fl_liw.busy", {31'd0, busy}, 32'd1);
    flush = 1'b1; in_instr = 16'h8123;
    #1 chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    chk("flush.busy", {31'd0, busy}, 32'd0);
    chk("flush.stale_kind", {30'd0, out_kind}, 32'd1);
    in_instr = 16'h1001;
    step();
    chk_out("post_flush", 1'b1, 16'h0001, 2'd1);

    // Async reset mid-cycle with a valid output pending.
    in_instr = 16'h81FF;
    step();
    chk_out("pre_rst", 1'b1, 16'hFFFF, 2'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 1'b0, 16'h0000, 2'd0);
    rst = 1'b0;
    in_valid = 1'b1; in_instr = 16'h0ABC;
    step();
    chk_out("op0", 1'b1, 16'h0000, 2'd0);

    // Reset in LIW_WAIT: the next word is decoded as an opcode.
    in_instr = 16'hF000;
    step();
    chk("rst_liw.busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    chk("rst_liw.busy_clr", {31'd0, busy}, 32'd0);
    in_valid = 1'b1; in_instr = 16'h8123;
    step();
    chk_out("rst_liw_dec", 1'b1, 16'hFF23, 2'd1);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
